// File: rtl/axis_level_streamer_v1_0.sv
// Paced AXI4-Stream source: samples a held level once per divider period into a
// one-deep output register, frames packets with tlast and counts dropped samples.
module axis_level_streamer_v1_0 #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 32,
  parameter int PACKET_LEN       = 16
) (
  input  logic                        aclk,
  input  logic                        arstn,
  input  logic                        cfg_enable,
  input  logic [CNT_WIDTH-1:0]        cfg_rate,
  input  logic [AXIS_TDATA_WIDTH-1:0] level_data,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [31:0]                 sts_drop_count
);

  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

  logic [CNT_WIDTH-1:0]        div_cnt_r;
  logic [BEAT_W-1:0]           beat_cnt_r;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_r;
  logic                        tvalid_r;
  logic                        tlast_r;
  logic [31:0]                 drop_cnt_r;

  logic [CNT_WIDTH-1:0] period_s;
  logic                 tick_s;
  logic                 slot_free_s;
  logic                 load_s;
  logic                 drop_s;
  logic                 last_beat_s;

  // Tick decode; >= lets a lowered rate fire immediately instead of waiting for wrap.
  always_comb begin
    period_s    = (cfg_rate == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : cfg_rate;
    tick_s      = cfg_enable && (div_cnt_r >= (period_s - CNT_WIDTH'(1)));
    slot_free_s = !tvalid_r || m_axis_tready;
    load_s      = tick_s && slot_free_s;
    drop_s      = tick_s && !slot_free_s;
    last_beat_s = (beat_cnt_r == LAST_BEAT);
  end

  // Sampling divider, held at zero while disabled.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      div_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (!cfg_enable || tick_s) begin
      div_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + CNT_WIDTH'(1);
    end
  end

  // One-deep output register and packet beat counter; a load overrides the drain.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      tdata_r    <= {AXIS_TDATA_WIDTH{1'b0}};
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (load_s) begin
      tdata_r    <= level_data;
      tvalid_r   <= 1'b1;
      tlast_r    <= last_beat_s;
      beat_cnt_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_cnt_r + BEAT_W'(1);
    end else if (tvalid_r && m_axis_tready) begin
      tvalid_r   <= 1'b0;
    end else begin
      tvalid_r   <= tvalid_r;
    end
  end

  // Saturating counter of ticks that found the output register occupied.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      drop_cnt_r <= 32'h0000_0000;
    end else if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
      drop_cnt_r <= drop_cnt_r + 32'h0000_0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign m_axis_tdata   = tdata_r;
  assign m_axis_tvalid  = tvalid_r;
  assign m_axis_tlast   = tlast_r;
  assign sts_drop_count = drop_cnt_r;

endmodule

// File: tb/tb_axis_level_streamer_v1_0.sv
// Scoreboard bench for axis_level_streamer_v1_0: expected beats are queued at the
// tick cycle and checked by a handshake monitor; each scenario checks timing inline.
module tb_axis_level_streamer_v1_0;

  logic        aclk = 1'b0;
  logic        arstn;
  logic        cfg_enable;
  logic [31:0] cfg_rate;
  logic [31:0] level_data;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [31:0] sts_drop_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_beat = 0;
  logic [32:0] sb[$];

  axis_level_streamer_v1_0 #(
    .AXIS_TDATA_WIDTH(32), .CNT_WIDTH(32), .PACKET_LEN(16)
  ) dut (
    .aclk(aclk), .arstn(arstn), .cfg_enable(cfg_enable), .cfg_rate(cfg_rate),
    .level_data(level_data), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .sts_drop_count(sts_drop_count)
  );

  always #5 aclk = ~aclk;

  // Handshake monitor: every delivered beat must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (arstn && m_axis_tvalid && m_axis_tready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got tdata=%h tlast=%b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        logic [32:0] exp;
        exp = sb.pop_front();
        if ({m_axis_tdata, m_axis_tlast} !== exp) begin
          n_fail++;
          $display("FAIL beat_data: got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                   m_axis_tdata, m_axis_tlast, exp[32:1], exp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d);
    logic l;
    l = (exp_beat == 15);
    sb.push_back({d, l});
    exp_beat = l ? 0 : exp_beat + 1;
  endtask

  task automatic check_drop(input string name, input logic [31:0] exp);
    n_checks++;
    if (sts_drop_count !== exp) begin
      n_fail++;
      $display("FAIL %s: sts_drop_count=%h required %h", name, sts_drop_count, exp);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic check_valid(input string name, input int i, input logic exp);
    n_checks++;
    if (m_axis_tvalid !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d tvalid=%b required %b", name, i, m_axis_tvalid, exp);
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0; cfg_enable = 1'b1; cfg_rate = 32'd1;
    level_data = 32'hDEAD_BEEF; m_axis_tready = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_drop_count} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_values: tvalid=%b tlast=%b tdata=%h drop=%h required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_drop_count);
    end
    cfg_enable = 1'b0; arstn = 1'b1;
    step();
  endtask

  task automatic test_pacing();
    cfg_rate = 32'd4; m_axis_tready = 1'b1; cfg_enable = 1'b1;
    for (int i = 0; i < 128; i++) begin
      check_valid("pacing_tvalid", i, (i >= 4) && (i % 4 == 0));
      level_data = 32'h1000_0000 + i;
      if (i % 4 == 3) push_beat(level_data);
      step();
    end
    cfg_enable = 1'b0;
    step(); step();
    check_drop("pacing_drop", 32'd0);
    check_drained("pacing_drained");
  endtask

  task automatic test_backpressure();
    cfg_rate = 32'd2; m_axis_tready = 1'b0; cfg_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2 && i <= 10) begin
        check_valid("bp_hold_valid", i, 1'b1);
        n_checks++;
        if (m_axis_tdata !== 32'h2000_0001) begin
          n_fail++;
          $display("FAIL bp_hold_data: cycle %0d tdata=%h required 20000001", i, m_axis_tdata);
        end
      end
      if (i == 10) m_axis_tready = 1'b1;
      level_data = 32'h2000_0000 + i;
      if (i == 1 || i == 11) push_beat(level_data);
      step();
    end
    cfg_enable = 1'b0;
    step(); step();
    check_drop("bp_drop", 32'd4);
    check_drained("bp_drained");
  endtask

  task automatic test_async_reset();
    cfg_rate = 32'd2; m_axis_tready = 1'b0; cfg_enable = 1'b1;
    level_data = 32'h3000_0000;
    step();
    push_beat(level_data);
    step();
    check_valid("arst_pending", 0, 1'b1);
    cfg_enable = 1'b0;
    #3 arstn = 1'b0;
    #1;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_drop_count} !== 66'd0) begin
      n_fail++;
      $display("FAIL arst_mid_beat: tvalid=%b tlast=%b tdata=%h drop=%h required all 0 before edge",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_drop_count);
    end
    sb.delete();
    exp_beat = 0;
    step();
    arstn = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    cfg_rate = 32'd0; m_axis_tready = 1'b1; cfg_enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 1) check_valid("b2b_tvalid", i, 1'b1);
      level_data = 32'h4000_0000 + i * 3;
      push_beat(level_data);
      step();
    end
    check_valid("b2b_tvalid_last", 40, 1'b1);
    cfg_enable = 1'b0;
    step(); step();
    check_drop("b2b_drop", 32'd0);
    check_drained("b2b_drained");
  endtask

  task automatic test_enable_gap();
    cfg_rate = 32'd2; m_axis_tready = 1'b0; cfg_enable = 1'b1;
    level_data = 32'h5000_0000;
    step();
    push_beat(level_data);
    step();
    cfg_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_valid("gap_hold", k, 1'b1);
      level_data = 32'h5555_0000 + k;
      step();
    end
    m_axis_tready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      check_valid("gap_idle", k, 1'b0);
      step();
    end
    check_drop("gap_drop", 32'd0);
    cfg_rate = 32'd3; cfg_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_valid("reenable_tvalid", i, i == 3);
      level_data = 32'h5100_0000 + i;
      if (i == 2 || i == 5) push_beat(level_data);
      step();
    end
    cfg_enable = 1'b0;
    step(); step();
    cfg_rate = 32'd100; cfg_enable = 1'b1;
    for (int i = 0; i < 52; i++) begin
      if (i == 50) cfg_rate = 32'd2;
      check_valid("rate_drop_tvalid", i, i == 51);
      level_data = 32'h5200_0000 + i;
      if (i == 50) push_beat(level_data);
      step();
    end
    cfg_enable = 1'b0;
    step(); step();
    check_drop("gap_drop_end", 32'd0);
    check_drained("gap_drained");
  endtask

  task automatic test_saturation();
    cfg_enable = 1'b0; m_axis_tready = 1'b0;
    force dut.drop_cnt_r = 32'hFFFF_FFFE;
    step();
    release dut.drop_cnt_r;
    step();
    check_drop("sat_preload", 32'hFFFF_FFFE);
    cfg_rate = 32'd0; cfg_enable = 1'b1;
    level_data = 32'h6000_0000;
    push_beat(level_data);
    step();
    step();
    check_drop("sat_reach", 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) step();
    check_drop("sat_hold", 32'hFFFF_FFFF);
    cfg_enable = 1'b0; m_axis_tready = 1'b1;
    step(); step();
    check_drained("sat_drained");
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_enable_gap();
    test_saturation();
    check_drained("final_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_level_streamer_v1_0.md
# axis_level_streamer_v1_0

- Converts a static, always-valid level (a configuration word or a held sample) into a paced AXI4-Stream that respects backpressure.
- A programmable divider samples `level_data` once per period into a one-deep output register, and `m_axis_tlast` frames every PACKET_LEN beats.
- Samples that cannot be accepted are dropped and counted.
- Typical use: streams a held level into DMA or FIFO capture paths at a fixed rate.

## Interface
- AXIS_TDATA_WIDTH, 32, width of `level_data` and `m_axis_tdata`
- CNT_WIDTH, 32, width of `cfg_rate` and of the divider counter
- PACKET_LEN, 16, beats per packet (>=1); the beat counter is $clog2(PACKET_LEN) bits, minimum 1
- aclk  in  1  clock; all logic on rising edge
- arstn  in  1  reset, asynchronous, active-low
- cfg_enable  in  1  1 = sampling ticks run; 0 = no new samples
- cfg_rate  in  CNT_WIDTH  tick period in aclk cycles; 0 and 1 both mean every cycle
- level_data  in  AXIS_TDATA_WIDTH  level to sample; no handshake
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  registered sample
- m_axis_tvalid  out  1  output register holds a beat
- m_axis_tlast  out  1  beat is last of packet
- sts_drop_count  out  32  saturating count of dropped ticks

## Operation
- Period P = max(cfg_rate, 1).
- **Divider** (div_cnt, CNT_WIDTH bits):
  - When cfg_enable=0: div_cnt forced to 0; tick=0.
  - When cfg_enable=1: tick = (div_cnt >= P-1). On tick, div_cnt <= 0; otherwise div_cnt <= div_cnt+1.
  - The `>=` compare handles a cfg_rate decrease mid-count: tick fires on the next cycle, no wrap-around wait.
- **Transfer** = m_axis_tvalid && m_axis_tready.
- **Slot free** = !m_axis_tvalid || m_axis_tready.
- **On tick with slot free (load):**
  - tdata <= level_data (sampled in the tick cycle).
  - tvalid <= 1.
  - tlast <= (beat_cnt == PACKET_LEN-1).
  - beat_cnt <= (beat_cnt == PACKET_LEN-1) ? 0 : beat_cnt+1.
- **On tick with slot not free (drop):**
  - Output register unchanged; tdata and tlast stay stable while tvalid is high, per the AXIS rule.
  - sts_drop_count increments, saturating at 32'hFFFF_FFFF.
- **On transfer without load:** tvalid <= 0; tdata and tlast keep their last values.
- **Transfer and tick in the same cycle:** load wins; tvalid stays 1 and the new beat follows back-to-back with no bubble.
- **Beat counting:** beat_cnt counts loaded beats. Every loaded beat is eventually delivered, so packet framing is exact.
- **Deassert cfg_enable:** a pending beat is still held and delivered. No drop is counted. beat_cnt is kept, so packets continue across enable gaps. Only arstn clears beat_cnt.
- **Changing level_data between ticks:** no effect on the output register.

## Timing
- Reset (arstn=0, asynchronous) clears: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, sts_drop_count=0, div_cnt=0, beat_cnt=0.
- Release is synchronous to aclk; the first tick can occur no earlier than the first edge after release.
- Latency: tick in cycle t → m_axis_tvalid=1 with the cycle-t level_data from cycle t+1.
- From cfg_enable rising in cycle e, ticks fall in cycles e+P-1, e+2P-1, ...
  - P=1: a tick every enabled cycle.
- Throughput: 1 beat/cycle maximum, at P=1 with tready held at 1.
- Reset asserted mid-beat: the beat is discarded; tvalid falls without a handshake. This is permitted only because it is a reset.
- No combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold arstn=0 with level_data=32'hDEAD_BEEF, cfg_enable=1 → all outputs 0. Assert arstn low asynchronously mid-beat → tvalid drops before the next edge.
- **Pacing:** cfg_rate=4, tready=1, level_data=cycle count, PACKET_LEN=16:
  - beats every 4 cycles, first at e+4;
  - each tdata equals level_data of the tick cycle;
  - tlast on beats 16 and 32;
  - sts_drop_count stays 0.
- **Backpressure/drop:** cfg_rate=2, tready=0 for 10 cycles:
  - first beat stays valid with stable tdata;
  - sts_drop_count=4 (5 ticks, 1 loaded);
  - after tready=1, beat delivered and the next loads on the following tick.
- **Back-to-back:** cfg_rate=0, tready=1 for 40 cycles → tvalid continuously 1, 40 beats, tlast exactly on beat indices 15 and 31, drop count 0.
- **Enable gap:** cfg_enable=0 while a beat is pending under tready=0:
  - beat is delivered when tready rises;
  - no new beats appear;
  - re-enabling with cfg_rate=3 gives the first beat at e+3, with beat_cnt continuing;
  - a cfg_rate change from 100 to 2 at div_cnt=50 ticks on the next cycle.
- **Saturation:** force sts_drop_count to all-ones via a long stall at P=1 (or a bench hierarchical deposit) → count holds at 32'hFFFF_FFFF.
